serial_shift_register: RTL and testbench

// - Serial-in, parallel-out shift register. Captures one bit per clock from a serial line
//   and presents the most recent WIDTH bits in parallel.
// - Used as a deserializer front end ahead of word-oriented logic. No handshake; shifts every cycle.
//

---
 rtl/serial_shift_register.sv | 85 ++++++++
 tb/tb_serial_shift_register.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/serial_shift_register.sv
// Serial-in, parallel-out shift register: captures one bit per Clk and presents the last WIDTH bits.
// Latency: a bit sampled at edge N is visible in Serial_Out after edge N and leaves after edge N+WIDTH.
// Backpressure: none; the register shifts on every rising edge while out of reset.
//
// Optional feature macro: SSR_FILL_VALID_EN adds Out_Valid and a saturating fill counter.
//
// Ports:
//   Clk         in   1      clock, rising-edge active
//   Rst_l       in   1      asynchronous active-low reset
//   Serial_In   in   1      serial data, sampled every rising edge
//   Serial_Out  out  WIDTH  parallel contents, straight from flops
//   Out_Valid   out  1      (SSR_FILL_VALID_EN only) high once WIDTH bits have been shifted in
//
// Parameters:
//   WIDTH       2..64, stored bit count
//   SHIFT_LEFT  1: newest bit at bit 0, older bits move toward MSB
//               0: newest bit at bit WIDTH-1, older bits move toward bit 0

module serial_shift_register #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned SHIFT_LEFT = 1
) (
  input  logic             Clk,
  input  logic             Rst_l,
  input  logic             Serial_In,
`ifdef SSR_FILL_VALID_EN
  output logic             Out_Valid,
`endif
  output logic [WIDTH-1:0] Serial_Out
);

  // Next register contents. Direction is fixed at elaboration, so only one
  // of the two concatenations survives synthesis.
  logic [WIDTH-1:0] shift_nxt;

  always_comb begin
    shift_nxt = Serial_Out;
    if (SHIFT_LEFT != 0) begin
      shift_nxt = {Serial_Out[WIDTH-2:0], Serial_In};
    end else begin
      shift_nxt = {Serial_In, Serial_Out[WIDTH-1:1]};
    end
  end

  // Serial_In is never looked at while Rst_l is low, so an X on the line
  // during reset cannot leak into the register.
  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l) begin
      Serial_Out <= '0;
    end else begin
      Serial_Out <= shift_nxt;
    end
  end

`ifdef SSR_FILL_VALID_EN
  // Fill counter: counts shifts since reset and saturates at WIDTH, so it
  // needs to represent 0..WIDTH inclusive.
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] fill_cnt;
  logic [CNT_W-1:0] fill_cnt_nxt;

  always_comb begin
    fill_cnt_nxt = fill_cnt;
    if (fill_cnt != CNT_FULL) begin
      fill_cnt_nxt = fill_cnt + CNT_ONE;
    end
  end

  // Out_Valid is registered from the next-count value so it rises on the
  // same edge as the WIDTH-th shift instead of one cycle later.
  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l) begin
      fill_cnt  <= '0;
      Out_Valid <= 1'b0;
    end else begin
      fill_cnt  <= fill_cnt_nxt;
      Out_Valid <= (fill_cnt_nxt == CNT_FULL);
    end
  end
`endif

endmodule

// File: tb/tb_serial_shift_register.sv
// Bench for serial_shift_register: two instances (left and right shift) fed from one serial line,
// checked after every edge against a history-of-bits reference model.
// Clock period 10, first rising edge at t=5; inputs change on falling edges.

module tb_serial_shift_register;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_l;
  logic         serial_in;
  logic [W-1:0] out_l;
  logic [W-1:0] out_r;
`ifdef SSR_FILL_VALID_EN
  logic         vld_l;
  logic         vld_r;
`endif

  int checks   = 0;
  int failures = 0;

  // Every bit accepted since the last reset, oldest first.
  bit hist[$];

  always #5 clk = ~clk;

  serial_shift_register #(.WIDTH(W), .SHIFT_LEFT(1)) u_left (
    .Clk        (clk),
    .Rst_l      (rst_l),
    .Serial_In  (serial_in),
`ifdef SSR_FILL_VALID_EN
    .Out_Valid  (vld_l),
`endif
    .Serial_Out (out_l)
  );

  serial_shift_register #(.WIDTH(W), .SHIFT_LEFT(0)) u_right (
    .Clk        (clk),
    .Rst_l      (rst_l),
    .Serial_In  (serial_in),
`ifdef SSR_FILL_VALID_EN
    .Out_Valid  (vld_r),
`endif
    .Serial_Out (out_r)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected word: the most recent W bits of history, newest at bit 0 for
  // a left shifter, newest at bit W-1 for a right shifter; unfilled slots 0.
  function automatic logic [W-1:0] model(input bit left);
    logic [W-1:0] r;
    int n;
    r = '0;
    n = hist.size();
    for (int age = 0; age < W; age++) begin
      if (age < n) begin
        if (left) r[age]       = hist[n-1-age];
        else      r[W-1-age]   = hist[n-1-age];
      end
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_left"},  64'(out_l), 64'(model(1'b1)));
    chk({tag, "_right"}, 64'(out_r), 64'(model(1'b0)));
`ifdef SSR_FILL_VALID_EN
    chk({tag, "_vld_left"},  64'(vld_l), 64'(hist.size() >= W));
    chk({tag, "_vld_right"}, 64'(vld_r), 64'(hist.size() >= W));
`endif
  endtask

  // Called on a falling edge: drive one bit, let one rising edge take it,
  // check just after the edge, return on the next falling edge.
  task automatic step(input bit b, input string tag);
    serial_in = b;
    @(posedge clk);
    hist.push_back(b);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    rst_l     = 1'b1;
    serial_in = 1'bx;

    // T1: reset held with X on the serial line
    #1 rst_l = 1'b0;
    #1 check_all("t1_async");
    @(posedge clk); #1 check_all("t1_edge1");
    @(posedge clk); #1 check_all("t1_edge2");

    // T2: release at t=20 and fill with 1,0,1,1
    @(negedge clk);
    rst_l = 1'b1;
    step(1'b1, "t2_b0");
    step(1'b0, "t2_b1");
    step(1'b1, "t2_b2");
    step(1'b1, "t2_b3");
    chk("t2_fill_left_const",  64'(out_l), 64'(4'b1011));
    chk("t2_fill_right_const", 64'(out_r), 64'(4'b1101));

    // T3: two more zeros push the oldest two bits out
    step(1'b0, "t3_b0");
    step(1'b0, "t3_b1");
    chk("t3_ovf_left_const",  64'(out_l), 64'(4'b1100));
    chk("t3_ovf_right_const", 64'(out_r), 64'(4'b0011));

    // T4: reset asserted mid-cycle clears immediately, refill starts from zero
    #2 rst_l = 1'b0;
    hist.delete();
    #1 check_all("t4_async_clear");
    serial_in = 1'b1;
    @(posedge clk); #1 check_all("t4_held_edge");
    @(negedge clk);
    rst_l = 1'b1;
    step(1'b1, "t4_refill");
    chk("t4_refill_left_const",  64'(out_l), 64'(4'b0001));
    chk("t4_refill_right_const", 64'(out_r), 64'(4'b1000));

    // T5: random bits, both shift directions against the model
    for (int i = 0; i < 10; i++) begin
      step(bit'($urandom_range(0, 1)), $sformatf("t5_rand%0d", i));
    end

    // T6: clean reset then watch the fill indication rise and stay high
    #2 rst_l = 1'b0;
    hist.delete();
    #1 check_all("t6_reset");
    @(negedge clk);
    rst_l = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(bit'($urandom_range(0, 1)), $sformatf("t6_fill%0d", i));
    end
`ifdef SSR_FILL_VALID_EN
    chk("t6_vld_const", 64'(vld_l), 64'(1));
`endif
    #2 rst_l = 1'b0;
    hist.delete();
    #1 check_all("t6_reassert");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
